// File: rtl/datapath_pkg.sv
// Shared datapath types and sizing constants for the scalar core.
package datapath_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned DMEM_DEPTH_WORDS = 1024;

endpackage : datapath_pkg

// File: rtl/scalar_dmem_array.sv
// Word-addressed storage behind the scalar data-memory responder.
// Synchronous write, combinational read.
module scalar_dmem_array
    import datapath_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output word_t            rdata
);

    word_t mem_q [DEPTH_WORDS];

    // Full-word write on the clock edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port follows the address with no clock delay.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule : scalar_dmem_array

// File: rtl/scalar_dmem_resp.sv
// Responder end of the scalar load/store data-memory handshake.
// Accepts a held request, waits LATENCY cycles, then pulses dhit for one
// cycle with read data or error status. Owns only the FSM, request latches
// and latency counter; storage lives in scalar_dmem_array.
module scalar_dmem_resp
    import datapath_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int unsigned LATENCY     = 2
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemaddr,
    input  word_t dmemstore,
    output logic  dhit,
    output word_t dmemload,
    output logic  derr,
    output logic  busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_INIT = cnt_t'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    dmem_state_t      state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       lo_q, lo_d;
    word_t            wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic             both_q, both_d;
    word_t            load_q, load_d;

    logic             req;
    logic             misaligned;
    logic             resp_ok;
    logic             arr_we;
    word_t            arr_rdata;
    word_t            rd_word;

    // Address bits above the array index alias and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^dmemaddr[31:IDX_W+2];

    scalar_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (CLK),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_q),
        .rdata (arr_rdata)
    );

    // Response qualification and output decode. dhit is gated by the live
    // request so a request dropped during RESP aborts without a pulse.
    always_comb begin
        req        = dmemREN | dmemWEN;
        misaligned = (lo_q != 2'b00);
        resp_ok    = (state_q == RESP) && req && !RST;
        arr_we     = resp_ok && wr_q && !misaligned;
        rd_word    = misaligned ? '0 : arr_rdata;
        dhit       = resp_ok;
        derr       = resp_ok && (misaligned || both_q);
        busy       = (state_q != IDLE);
        dmemload   = (resp_ok && !wr_q) ? rd_word : load_q;
    end

    // Next-state, latch and counter logic for the IDLE/WAIT/RESP handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        both_d  = both_q;
        load_d  = load_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = dmemaddr[2 +: IDX_W];
                    lo_d    = dmemaddr[1:0];
                    wdata_d = dmemstore;
                    wr_d    = dmemWEN;
                    both_d  = dmemREN & dmemWEN;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    // Leave once this decrement reaches zero so dhit lands on cycle LATENCY.
                    cnt_d = cnt_q - cnt_t'(1);
                    if (cnt_q == cnt_t'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (resp_ok && !wr_q) begin
                    load_d = rd_word;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            load_q  <= load_d;
        end
    end

endmodule : scalar_dmem_resp

// File: tb/tb_scalar_dmem_resp.sv
// Directed bench for scalar_dmem_resp: table of single transactions on a
// LATENCY=2 instance plus hand sequences for held, aborted, reset and
// LATENCY=1 cases.
module tb_scalar_dmem_resp;
    import datapath_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    logic  ren, wen;
    word_t addr, store;

    logic  hit_a, err_a, busy_a;
    word_t load_a;
    logic  hit_b, err_b, busy_b;
    word_t load_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    scalar_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
        .CLK(CLK), .RST(RST), .dmemREN(ren), .dmemWEN(wen),
        .dmemaddr(addr), .dmemstore(store),
        .dhit(hit_a), .dmemload(load_a), .derr(err_a), .busy(busy_a)
    );

    scalar_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_b (
        .CLK(CLK), .RST(RST), .dmemREN(ren), .dmemWEN(wen),
        .dmemaddr(addr), .dmemstore(store),
        .dhit(hit_b), .dmemload(load_b), .derr(err_b), .busy(busy_b)
    );

    typedef struct {
        logic  r;
        logic  w;
        word_t a;
        word_t d;
        logic  err;
        word_t load;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    // Entered at posedge+1 with the DUT idle; returns the same way.
    task automatic run_txn(input int unsigned lat, input bit use_b,
                           input logic r, input logic w, input word_t a, input word_t d,
                           input logic exp_err, input word_t exp_load, input string tag);
        ren = r; wen = w; addr = a; store = d;
        for (int unsigned c = 0; c <= lat; c++) begin
            @(negedge CLK);
            chk({tag, "/dhit"}, use_b ? hit_b : hit_a, (c == lat));
            chk({tag, "/busy"}, use_b ? busy_b : busy_a, (c != 0));
            if (c == lat) begin
                chk({tag, "/derr"}, use_b ? err_b : err_a, exp_err);
                chk({tag, "/load"}, use_b ? load_b : load_a, exp_load);
            end
            next_cycle();
        end
        ren = 1'b0; wen = 1'b0;
        @(negedge CLK);
        chk({tag, "/idle_busy"}, use_b ? busy_b : busy_a, 1'b0);
        chk({tag, "/idle_dhit"}, use_b ? hit_b : hit_a, 1'b0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0]  = '{r:1'b0, w:1'b1, a:32'h0000_0040, d:32'hDEAD_BEEF, err:1'b0, load:32'h0000_0000};
        vt[1]  = '{r:1'b1, w:1'b0, a:32'h0000_0040, d:32'h0,         err:1'b0, load:32'hDEAD_BEEF};
        vt[2]  = '{r:1'b1, w:1'b0, a:32'h0000_0042, d:32'h0,         err:1'b1, load:32'h0000_0000};
        vt[3]  = '{r:1'b1, w:1'b0, a:32'h0000_0040, d:32'h0,         err:1'b0, load:32'hDEAD_BEEF};
        vt[4]  = '{r:1'b0, w:1'b1, a:32'h0000_1000, d:32'hA5A5_A5A5, err:1'b0, load:32'hDEAD_BEEF};
        vt[5]  = '{r:1'b1, w:1'b0, a:32'h0000_0000, d:32'h0,         err:1'b0, load:32'hA5A5_A5A5};
        vt[6]  = '{r:1'b0, w:1'b1, a:32'h0000_0044, d:32'h1234_5678, err:1'b0, load:32'hA5A5_A5A5};
        vt[7]  = '{r:1'b1, w:1'b0, a:32'hFFFF_F044, d:32'h0,         err:1'b0, load:32'h1234_5678};
        vt[8]  = '{r:1'b1, w:1'b1, a:32'h0000_0048, d:32'h0000_0055, err:1'b1, load:32'h1234_5678};
        vt[9]  = '{r:1'b0, w:1'b1, a:32'h0000_0041, d:32'hFFFF_FFFF, err:1'b1, load:32'h1234_5678};
        vt[10] = '{r:1'b1, w:1'b0, a:32'h0000_0040, d:32'h0,         err:1'b0, load:32'hDEAD_BEEF};

        RST = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; store = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst/dhit_a", hit_a, 1'b0);
        chk("rst/derr_a", err_a, 1'b0);
        chk("rst/busy_a", busy_a, 1'b0);
        chk("rst/load_a", load_a, 32'h0);
        chk("rst/dhit_b", hit_b, 1'b0);
        chk("rst/load_b", load_b, 32'h0);
        next_cycle();

        for (int i = 0; i < 11; i++) begin
            run_txn(2, 1'b0, vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].err, vt[i].load,
                    $sformatf("vec%0d", i));
        end

        // Held read: a new transaction every LATENCY+1 cycles.
        ren = 1'b1; addr = 32'h40;
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            chk($sformatf("held/dhit%0d", c), hit_a, (c % 3 == 2));
            chk($sformatf("held/busy%0d", c), busy_a, (c % 3 != 0));
            if (c % 3 == 2) chk($sformatf("held/load%0d", c), load_a, 32'hDEAD_BEEF);
            next_cycle();
        end
        ren = 1'b0;
        @(negedge CLK);
        chk("held/end_busy", busy_a, 1'b0);
        next_cycle();

        // Abort in WAIT.
        ren = 1'b1; addr = 32'h80;
        @(negedge CLK);
        chk("abw/c0_busy", busy_a, 1'b0);
        next_cycle();
        ren = 1'b0;
        @(negedge CLK);
        chk("abw/c1_dhit", hit_a, 1'b0);
        chk("abw/c1_busy", busy_a, 1'b1);
        next_cycle();
        @(negedge CLK);
        chk("abw/c2_dhit", hit_a, 1'b0);
        chk("abw/c2_busy", busy_a, 1'b0);
        next_cycle();
        run_txn(2, 1'b0, 1'b0, 1'b1, 32'h80, 32'h1, 1'b0, 32'hDEAD_BEEF, "abw_wr");
        run_txn(2, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0000_0001, "abw_rd");

        // Write dropped during RESP: no pulse, no array update.
        wen = 1'b1; addr = 32'h40; store = 32'h77;
        next_cycle();
        @(negedge CLK);
        chk("abr/c1_busy", busy_a, 1'b1);
        next_cycle();
        wen = 1'b0;
        @(negedge CLK);
        chk("abr/c2_dhit", hit_a, 1'b0);
        chk("abr/c2_busy", busy_a, 1'b1);
        next_cycle();
        @(negedge CLK);
        chk("abr/c3_busy", busy_a, 1'b0);
        next_cycle();
        run_txn(2, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF, "abr_rd");

        // Reset mid-transaction.
        wen = 1'b1; addr = 32'h40; store = 32'h2;
        next_cycle();
        RST = 1'b1; wen = 1'b0;
        @(negedge CLK);
        chk("rstm/c1_dhit", hit_a, 1'b0);
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        chk("rstm/dhit", hit_a, 1'b0);
        chk("rstm/busy", busy_a, 1'b0);
        chk("rstm/load", load_a, 32'h0);
        next_cycle();
        run_txn(2, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF, "rstm_rd");

        // LATENCY=1 instance from a clean reset.
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        next_cycle();
        run_txn(1, 1'b1, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, "l1_wr");
        run_txn(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD_BEEF, "l1_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_scalar_dmem_resp
